uart_alu_bridge: RTL and testbench
==================================

# uart_alu_bridge

Command/response bridge between the UART receiver, the ALU and the UART transmitter inside `top`. It consumes received bytes as a framed command (header, operand A, operand B, opcode), drives registered operands and opcode into the combinational ALU, and hands the 8-bit result to the transmitter with a start/done handshake. An inter-byte timeout discards partial frames so the link always recovers.

## Interface
- `NB_DATA`, 8, width of bytes, operands and result
- `NB_OP`, 6, opcode width; the low `NB_OP` bits of the opcode byte are used
- `HEADER`, 8'hFF, frame start byte
- `TIMEOUT_CYCLES`, 2_000_000, maximum idle clocks between bytes inside a frame (20 ms at 100 MHz)

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rx_done_tick`  in  1  one-cycle pulse; `rx_data` is valid this cycle
- `rx_data`  in  NB_DATA  received byte
- `alu_result`  in  NB_DATA  combinational ALU output
- `alu_a`  out  NB_DATA  registered operand A
- `alu_b`  out  NB_DATA  registered operand B
- `alu_op`  out  NB_OP  registered opcode
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`
- `tx_data`  out  NB_DATA  registered result byte
- `tx_done_tick`  in  1  one-cycle pulse from the transmitter at end of stop bit
- `busy`  out  1  high in every state except IDLE
- `timeout_err`  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- Reset: state IDLE; `alu_a`, `alu_b`, `alu_op`, `tx_data`, `tx_start`, `busy`, `timeout_err` = 0; timeout counter = 0.
- States: IDLE, GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: on `rx_done_tick` with `rx_data == HEADER` go to GET_A. Any other byte is ignored.
- GET_A / GET_B: on `rx_done_tick` load `alu_a` / `alu_b` with `rx_data` and advance. Inside a frame a byte equal to `HEADER` is plain data; there is no resync.
- GET_OP: on `rx_done_tick` load `alu_op <= rx_data[NB_OP-1:0]` and go to EXEC.
- EXEC: one settle cycle. Latch `tx_data <= alu_result`, register `tx_start <= 1`, go to SEND.
- SEND: `tx_start` is high for exactly this cycle. Go to WAIT_TX.
- WAIT_TX: on `tx_done_tick` go to IDLE.
- Operands and opcode hold their values after the frame until overwritten by the next frame. The bridge does no arithmetic; width and wrap behaviour are the ALU's.
- Timeout counter:
  - Runs only in GET_A, GET_B and GET_OP. It clears on every `rx_done_tick` and on entry to GET_A.
  - When it reaches `TIMEOUT_CYCLES-1` with no `rx_done_tick` that cycle: go to IDLE and pulse `timeout_err` for one cycle.
  - Partially loaded operand registers keep their new values.
- Boundary rules:
  - `rx_done_tick` in EXEC, SEND or WAIT_TX is dropped, with no buffering.
  - `tx_done_tick` outside WAIT_TX is ignored.
  - A byte arriving on the expiry cycle is accepted and the timeout does not fire.
  - `reset` asserted mid-frame or mid-transmission returns immediately to the reset values.

## Timing
- Opcode byte `rx_done_tick` in cycle k:
  - `alu_op` is valid from cycle k+1 (EXEC).
  - `tx_data` is valid and `tx_start` is high in cycle k+2.
  - `tx_start` is low from k+3.
- Operand latency: `alu_a` / `alu_b` update on the edge ending the `rx_done_tick` cycle.
- `busy` rises the cycle after the header is accepted. It falls the cycle after `tx_done_tick` or after the timeout.
- `timeout_err` is registered and coincides with the first IDLE cycle.
- The ALU is combinational. The bridge requires the ALU result to settle within one clock period.

## Test plan
- Frame FF,03,02,20 at 9600 baud with a behavioural ADD ALU: `alu_a`=03, `alu_b`=02, `alu_op`=20, `tx_data`=05, single `tx_start` pulse two cycles after the opcode tick; `busy` drops after `tx_done_tick`.
- Junk bytes 11,22 before FF,07,01,22 (SUB): junk is ignored and `tx_data`=06.
- With `TIMEOUT_CYCLES`=2000, send FF,03 then stay idle: `timeout_err` pulses once and the state returns to IDLE; the next frame FF,04,04,20 gives `tx_data`=08.
- Bytes injected during WAIT_TX are dropped: `alu_a`, `alu_b` and `alu_op` stay unchanged and there is no second `tx_start`.
- Frame FF,FF,01,20: FF is accepted as operand A and `tx_data`=00 (ALU wrap).
- `reset` pulsed after the B byte: all outputs return to 0, and a following full frame completes normally.

Source files
------------

// File: rtl/uart_alu_bridge_if.sv
// Bundle of the bridge-facing UART receiver, ALU and UART transmitter signals.
// master: the bridge (drives operands, opcode, tx request, status).
// slave: the surrounding receiver/ALU/transmitter environment.
interface uart_alu_bridge_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               rx_done_tick;
  logic [NB_DATA-1:0] rx_data;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_done_tick;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  rx_done_tick, rx_data, alu_result, tx_done_tick,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout_err
  );

  modport slave (
    output rx_done_tick, rx_data, alu_result, tx_done_tick,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, timeout_err
  );
endinterface

// File: rtl/uart_alu_bridge.sv
// Frames received bytes (HEADER, A, B, OP) into ALU operands and sends the result byte to the UART tx.
// Latency: tx_start is high two cycles after the opcode byte's rx_done_tick.
// Backpressure: none on rx; bytes arriving while executing/transmitting are dropped, tx waits for tx_done_tick.
module uart_alu_bridge #(
  parameter int                 NB_DATA        = 8,
  parameter int                 NB_OP          = 6,
  parameter logic [NB_DATA-1:0] HEADER         = {NB_DATA{1'b1}},
  parameter int                 TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  uart_alu_bridge_if.master bus
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_A,
    S_GET_B,
    S_GET_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               tout_q, tout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               expired;

  // Inter-byte idle counter has hit its limit this cycle.
  assign expired = (cnt_q == CNT_LAST);

  // State and datapath registers; async reset returns everything to zero/IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      tout_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      tout_q     <= tout_d;
      cnt_q      <= cnt_d;
    end
  end

  // Frame sequencing, operand capture, timeout and tx request generation.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    tout_d     = 1'b0;
    // Counter is zero outside the byte-collecting states, so entry to GET_A starts from zero.
    cnt_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_done_tick && (bus.rx_data == HEADER)) begin
          state_d = S_GET_A;
        end
      end

      // Inside a frame a HEADER value is ordinary data; no resync.
      S_GET_A: begin
        if (bus.rx_done_tick) begin
          a_d     = bus.rx_data;
          state_d = S_GET_B;
        end else if (expired) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GET_B: begin
        if (bus.rx_done_tick) begin
          b_d     = bus.rx_data;
          state_d = S_GET_OP;
        end else if (expired) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GET_OP: begin
        if (bus.rx_done_tick) begin
          op_d    = bus.rx_data[NB_OP-1:0];
          state_d = S_EXEC;
        end else if (expired) begin
          state_d = S_IDLE;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // ALU has had one full cycle with the new operands; capture its result.
      S_EXEC: begin
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        state_d = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (bus.tx_done_tick) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.timeout_err = tout_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Randomized frame-level bench for uart_alu_bridge with a behavioural ALU.
// Driver pushes expected tx/timeout events; a negedge monitor pops and compares them.
// Expected cycle numbers come from byte tick times and the timeout length.
module tb_uart_alu_bridge;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TOUT    = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_alu_bridge_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus();

  uart_alu_bridge #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .HEADER(8'hFF), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h26:   r = a ^ b;
      6'h27:   r = ~(a | b);
      6'h02:   r = a >> b;
      6'h03:   r = $signed(a) >>> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  typedef struct {
    bit         is_to;
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];

  // Frame-level model of operand registers.
  logic [7:0] a_m = 8'h00;
  logic [7:0] b_m = 8'h00;
  logic [5:0] op_m = 6'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every tx_start or timeout_err must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (bus.tx_start || bus.timeout_err)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: tx_start=%0b timeout_err=%0b with nothing expected (cycle %0d)",
                 bus.tx_start, bus.timeout_err, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_is_timeout", 32'(bus.timeout_err), 32'(e.is_to));
        chk("event_tx_start", 32'(bus.tx_start), 32'(!e.is_to));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_alu_a", 32'(bus.alu_a), 32'(e.a));
        chk("event_alu_b", 32'(bus.alu_b), 32'(e.b));
        chk("event_alu_op", 32'(bus.alu_op), 32'(e.op));
        if (!e.is_to) chk("tx_data", 32'(bus.tx_data), 32'(e.d));
      end
    end
  end

  // Driver tasks: entered and left at posedge+1.
  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      bus.tx_done_tick = spur && (i == 0);
      @(posedge clk);
      #1;
    end
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic tick(input logic [7:0] d, output int kc);
    bus.rx_data      = d;
    bus.rx_done_tick = 1'b1;
    kc = cyc;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input int ga, input int gb, input int go, input bit inj, input bit spur);
    int kc;
    idle(1 + $urandom_range(0, 2), 1'b0);
    tick(8'hFF, kc);
    idle(ga, spur);
    tick(a, kc);
    a_m = a;
    idle(gb, 1'b0);
    tick(b, kc);
    b_m = b;
    idle(go, 1'b0);
    op_m = opb[5:0];
    q.push_back('{is_to: 1'b0, cyc: cyc + 2, a: a_m, b: b_m, op: op_m, d: alu_fn(op_m, a_m, b_m)});
    tick(opb, kc);
    idle(2, 1'b0);
    if (inj) begin
      for (int i = 0; i < 3; i++) begin
        tick((i == 0) ? 8'hFF : 8'($urandom_range(0, 255)), kc);
        idle($urandom_range(0, 1), 1'b0);
      end
      chk("drop_alu_a", 32'(bus.alu_a), 32'(a_m));
      chk("drop_alu_b", 32'(bus.alu_b), 32'(b_m));
      chk("drop_alu_op", 32'(bus.alu_op), 32'(op_m));
    end
    idle($urandom_range(0, 6), 1'b0);
    chk("busy_wait_tx", 32'(bus.busy), 32'd1);
    bus.tx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done_tick = 1'b0;
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic truncated(input int nbytes);
    int kc;
    logic [7:0] v;
    idle(1 + $urandom_range(0, 2), 1'b0);
    tick(8'hFF, kc);
    for (int i = 0; i < nbytes; i++) begin
      idle($urandom_range(0, 4), 1'b0);
      v = 8'($urandom_range(0, 255));
      tick(v, kc);
      if (i == 0) a_m = v;
      else b_m = v;
    end
    q.push_back('{is_to: 1'b1, cyc: kc + TOUT + 1, a: a_m, b: b_m, op: op_m, d: 8'h00});
    idle(TOUT + 3, 1'b0);
    chk("busy_after_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
    chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  task automatic reset_mid();
    int kc;
    idle(1, 1'b0);
    tick(8'hFF, kc);
    tick(8'($urandom_range(0, 255)), kc);
    tick(8'($urandom_range(0, 255)), kc);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_m = 8'h00; b_m = 8'h00; op_m = 6'h00;
  endtask

  function automatic logic [7:0] rand_op();
    logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
    logic [5:0] o;
    o = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
    return {2'($urandom), o};
  endfunction

  initial begin
    int kc;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    idle(2, 1'b0);

    // Basic ADD frame.
    frame(8'h03, 8'h02, 8'h20, 2, 3, 1, 1'b0, 1'b0);
    chk("add_tx_data", 32'(bus.tx_data), 32'h05);
    // Junk before the header is ignored.
    tick(8'h11, kc);
    idle(2, 1'b1);
    tick(8'h22, kc);
    frame(8'h07, 8'h01, 8'h22, 0, 0, 0, 1'b0, 1'b0);
    chk("sub_tx_data", 32'(bus.tx_data), 32'h06);
    // Partial frame times out, next frame recovers.
    truncated(1);
    frame(8'h04, 8'h04, 8'h20, 1, 1, 1, 1'b0, 1'b0);
    chk("recover_tx_data", 32'(bus.tx_data), 32'h08);
    // Bytes during WAIT_TX are dropped.
    frame(8'h10, 8'h20, 8'h25, 0, 1, 2, 1'b1, 1'b0);
    // HEADER value as operand A, 8-bit wrap.
    frame(8'hFF, 8'h01, 8'h20, 0, 0, 0, 1'b0, 1'b0);
    chk("wrap_tx_data", 32'(bus.tx_data), 32'h00);
    // Reset after B byte, then a full frame.
    reset_mid();
    frame(8'h09, 8'h05, 8'h22, 1, 1, 1, 1'b0, 1'b0);
    chk("post_reset_tx_data", 32'(bus.tx_data), 32'h04);
    // Bytes landing exactly on the expiry cycle are accepted.
    frame(8'h21, 8'h12, 8'h26, TOUT - 1, TOUT - 1, TOUT - 1, 1'b0, 1'b1);
    truncated(2);
    truncated(0);

    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        if ($urandom_range(0, 2) == 0) begin
          tick(8'($urandom_range(0, 254)), kc);
        end
        frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op(),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (sel <= 7) begin
        truncated($urandom_range(0, 2));
      end else if (sel == 8) begin
        reset_mid();
      end else begin
        frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rand_op(),
              TOUT - 1, $urandom_range(0, 3), TOUT - 1, 1'b0, 1'b0);
      end
    end

    idle(5, 1'b0);
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_outputs: %0d expected events never seen, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
